mlp_feature_sequencer: RTL
==========================

# mlp_feature_sequencer

Sequential front-end for the combinational Vertebral_Column_3C MLP classifier. It accepts the six 4-bit quantized features one per beat over a valid/ready stream and packs them into the 24-bit `inp` vector that drives the classifier. It holds that vector stable while the classifier settles, then registers the 2-bit class prediction and presents it on a valid/ready result port.

## Interface
- `NUM_FEAT`, default 6: features per frame.
- `FEAT_W`, default 4: bits per feature.
- `CLS_W`, default 2: class index width.
- `SETTLE_CYCLES`, default 2: cycles the classifier gets to settle before its output is sampled. Legal range is 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `feat_valid`  in  1  feature beat valid.
- `feat_ready`  out  1  sequencer accepts a beat.
- `feat_data`  in  FEAT_W  feature value, unsigned.
- `feat_last`  in  1  marks the final feature of a frame.
- `clf_inp`  out  NUM_FEAT*FEAT_W  packed vector to the classifier `inp`.
- `clf_out`  in  CLS_W  classifier `out`.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  consumer accepts the result.
- `res_class`  out  CLS_W  registered class index.
- `err_frame`  out  1  one-cycle pulse when a frame is aborted because of framing.

## Operation
- The FSM has three states: COLLECT, SETTLE and HOLD. Reset enters COLLECT.
- **COLLECT**
  - `feat_ready` = 1.
  - A beat transfers when `feat_valid` and `feat_ready` are both high.
  - Beat k (k = 0..5) writes `clf_inp[k*FEAT_W +: FEAT_W]`, so feature 0 lands in bits [3:0] and feature 5 in bits [23:20].
  - The 3-bit index `idx` increments on each beat.
- **Framing check**
  - `feat_last` is required on beat 5 and forbidden on beats 0..4.
  - On a mismatch, the beat is dropped, `err_frame` pulses, `idx` returns to 0, and the FSM stays in COLLECT.
  - Slots already written keep stale data; the next frame overwrites them.
- **Good beat 5**: write the slot and go to SETTLE with the settle counter cleared.
- **SETTLE**
  - `feat_ready` = 0 and `clf_inp` is frozen.
  - The counter increments each cycle.
  - On the cycle where the counter equals SETTLE_CYCLES-1, register `clf_out` into `res_class` and go to HOLD.
- **HOLD**
  - `res_valid` = 1, with `res_class` and `clf_inp` held stable.
  - On `res_ready` = 1, go to COLLECT with `idx` = 0.
  - `feat_ready` stays 0 throughout HOLD, including the handshake cycle, so there is no overlap.
- **Reset** (asynchronous, any state, including mid-frame or in HOLD) clears:
  - state to COLLECT, and `idx` and the counter to 0;
  - `clf_inp` to 0, `res_class` to 0;
  - `res_valid` to 0, `err_frame` to 0.
- **Output reset values**: `feat_ready` is 0 while `rst` is high and 1 from the first cycle after release. All other outputs are 0.
- **Arithmetic**: no arithmetic on data; features pass through unmodified and unsigned. The counter is 4 bits wide and never wraps, because it exits at SETTLE_CYCLES-1.

## Timing
- All outputs are registered or decoded only from the state register. There is no combinational path from `feat_valid` to `feat_ready`, or from `res_ready` to `res_valid`.
- If the final good beat handshakes at edge t, SETTLE occupies cycles t+1 .. t+SETTLE_CYCLES.
- `res_valid` rises after edge t+SETTLE_CYCLES.
- Frame-to-result latency is SETTLE_CYCLES+1 cycles from the last beat.
- Best-case throughput is one frame per 6 + SETTLE_CYCLES + 1 cycles, with `res_ready` tied high.
- `err_frame` is asserted in the cycle after the offending handshake, for exactly one cycle.
- `res_valid` stays high until the handshake. `res_class` must not change while `res_valid` = 1.

## Structure
- A shared package `mlp_seq_pkg` holds:
  - the constants NUM_FEAT, FEAT_W, CLS_W and VEC_W = NUM_FEAT*FEAT_W;
  - the enum `seq_state_t` {COLLECT, SETTLE, HOLD}.
- No sub-module. The classifier is instantiated alongside the sequencer at the next level up, not inside it, so generated network netlists swap in without touching this block.

## Test plan
- **Nominal frame**: send features 1..6 with `feat_last` on the sixth beat and `res_ready` = 1. Require:
  - `clf_inp` = 24'h654321;
  - `res_class` equals the model prediction for that vector;
  - `res_valid` rises exactly 3 cycles after the last beat, with SETTLE_CYCLES = 2.
- **Early `feat_last`** on beat 2: `err_frame` pulses once, `res_valid` stays 0, and a following good frame produces a correct result.
- **Missing `feat_last`** on beat 5: the beat is dropped, `err_frame` pulses, and the FSM returns to COLLECT.
- **Backpressure**: hold `res_ready` = 0 for 10 cycles in HOLD. Require `res_valid`, `res_class` and `clf_inp` stable, `feat_ready` = 0 throughout, and `feat_ready` = 1 in the cycle after the handshake.
- **Reset mid-operation**: assert `rst` after beat 3, and separately during HOLD. All outputs must go to 0 immediately, and a subsequent full frame must classify correctly.
- **SETTLE_CYCLES = 1 and = 15** with random `feat_valid` gaps: check the latency formula holds and that no beat is accepted outside COLLECT.

Source files
------------

// File: rtl/mlp_seq_pkg.sv
// Shared constants and state encoding for the MLP feature sequencer.
// Frame geometry lives here so the classifier wrapper and sequencer agree on widths.
package mlp_seq_pkg;

    localparam int unsigned NUM_FEAT = 6;
    localparam int unsigned FEAT_W   = 4;
    localparam int unsigned CLS_W    = 2;
    localparam int unsigned VEC_W    = NUM_FEAT * FEAT_W;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SETTLE  = 2'd1,
        HOLD    = 2'd2
    } seq_state_t;

endpackage

// File: rtl/mlp_feature_sequencer.sv
// Packs a stream of quantized features into the classifier input vector, waits for the
// combinational classifier to settle, then presents the registered class on a valid/ready port.
module mlp_feature_sequencer
    import mlp_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              feat_valid,
    output logic              feat_ready,
    input  logic [FEAT_W-1:0] feat_data,
    input  logic              feat_last,
    output logic [VEC_W-1:0]  clf_inp,
    input  logic [CLS_W-1:0]  clf_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CLS_W-1:0]  res_class,
    output logic              err_frame
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FEAT - 1);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [VEC_W-1:0] inp_q, inp_d;
    logic [CLS_W-1:0] cls_q, cls_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;

    logic beat_c;
    logic last_slot_c;
    logic frame_ok_c;
    logic settle_done_c;

    // ready_q is only ever high in COLLECT, so it doubles as the acceptance qualifier
    assign beat_c        = feat_valid & ready_q;
    assign last_slot_c   = (idx_q == IDX_LAST);
    assign frame_ok_c    = (feat_last == last_slot_c);
    assign settle_done_c = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT: if (beat_c && frame_ok_c && last_slot_c) state_d = SETTLE;
            SETTLE:  if (settle_done_c) state_d = HOLD;
            HOLD:    if (res_ready) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Datapath updates; a misframed beat is dropped and leaves stale slots behind
    always_comb begin
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        inp_d   = inp_q;
        cls_d   = cls_q;
        err_d   = 1'b0;
        ready_d = (state_d == COLLECT);
        unique case (state_q)
            COLLECT: begin
                cnt_d = '0;
                if (beat_c) begin
                    if (frame_ok_c) begin
                        for (int unsigned k = 0; k < NUM_FEAT; k++) begin
                            if (idx_q == IDX_W'(k)) inp_d[k*FEAT_W +: FEAT_W] = feat_data;
                        end
                        idx_d = last_slot_c ? '0 : idx_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                        idx_d = '0;
                    end
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (settle_done_c) begin
                    cls_d = clf_out;
                    cnt_d = '0;
                end
            end
            HOLD: begin
                if (res_ready) idx_d = '0;
            end
            default: begin
                idx_d = '0;
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            inp_q   <= '0;
            cls_q   <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            inp_q   <= inp_d;
            cls_q   <= cls_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign feat_ready = ready_q;
    assign clf_inp    = inp_q;
    assign res_valid  = (state_q == HOLD);
    assign res_class  = cls_q;
    assign err_frame  = err_q;

endmodule
